// File: rtl/id_imm_gen_stage_pkg.sv
// Shared decode definitions: immediate format enum, RV opcodes and sign extension helper.
package id_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OP     = 7'b0110011;

  // Every format is first assembled as a 32-bit value whose bit 31 is inst[31],
  // so widening from bit 31 gives the correct result for any XLEN up to 64.
  function automatic logic [63:0] sext(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/id_imm_gen_stage_if.sv
// Handshake bundle between IF/ID, the immediate stage and ID/EX.
interface id_imm_gen_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_target;

  // Upstream/downstream environment view.
  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc, out_target
  );

  // Stage view.
  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc, out_target
  );
endinterface

// File: rtl/id_imm_gen_stage_imm_decode.sv
// Combinational immediate decoder: instruction word -> sign-extended imm, format, illegal flag.
module imm_decode
  import id_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  logic [31:0] raw;

  // Select the format from the opcode and assemble its 32-bit immediate.
  always_comb begin
    raw     = '0;
    fmt     = FMT_ILL;
    illegal = 1'b0;
    case (inst[6:0])
      OP_IMM, LOAD, JALR, SYSTEM: begin
        fmt = FMT_I;
        raw = {{20{inst[31]}}, inst[31:20]};
      end
      STORE: begin
        fmt = FMT_S;
        raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      BRANCH: begin
        fmt = FMT_B;
        raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      LUI, AUIPC: begin
        fmt = FMT_U;
        raw = {inst[31:12], 12'b0};
      end
      JAL: begin
        fmt = FMT_J;
        raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OP: begin
        fmt = FMT_R;
        raw = '0;
      end
      default: begin
        fmt     = FMT_ILL;
        illegal = 1'b1;
        raw     = '0;
      end
    endcase
  end

  assign imm = XLEN'(sext(raw));

endmodule

// File: rtl/id_imm_gen_stage.sv
// Registered ID-stage immediate generator with valid/ready handshake and optional skid entry.
module id_imm_gen_stage
  import id_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EN_TARGET = 1'b1,
  parameter bit SKID      = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  input logic                flush,
  id_imm_gen_stage_if.slave  bus
);

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_target;

  imm_decode #(.XLEN(XLEN)) u_imm_decode (
    .inst    (bus.in_inst),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign dec_target = EN_TARGET ? (bus.in_pc + dec_imm) : '0;

  logic            out_valid_q;
  logic [XLEN-1:0] out_imm_q;
  imm_fmt_e        out_fmt_q;
  logic            out_illegal_q;
  logic [XLEN-1:0] out_pc_q;
  logic [XLEN-1:0] out_target_q;

  logic            skid_valid_q;
  logic [XLEN-1:0] skid_imm_q;
  imm_fmt_e        skid_fmt_q;
  logic            skid_illegal_q;
  logic [XLEN-1:0] skid_pc_q;
  logic [XLEN-1:0] skid_target_q;

  logic in_ready_q;
  logic in_ready;
  logic out_free;
  logic accept;

  // Output slot can take a new entry when it is empty or being consumed this cycle.
  assign out_free = ~out_valid_q | bus.out_ready;
  assign in_ready = SKID ? in_ready_q : out_free;
  assign accept   = bus.in_valid & in_ready;

  // Output register, skid entry and registered ready; skid always drains before new input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_imm_q      <= '0;
      out_fmt_q      <= FMT_R;
      out_illegal_q  <= 1'b0;
      out_pc_q       <= '0;
      out_target_q   <= '0;
      skid_valid_q   <= 1'b0;
      skid_imm_q     <= '0;
      skid_fmt_q     <= FMT_R;
      skid_illegal_q <= 1'b0;
      skid_pc_q      <= '0;
      skid_target_q  <= '0;
      in_ready_q     <= 1'b1;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      if (out_free) begin
        if (skid_valid_q) begin
          out_valid_q   <= 1'b1;
          out_imm_q     <= skid_imm_q;
          out_fmt_q     <= skid_fmt_q;
          out_illegal_q <= skid_illegal_q;
          out_pc_q      <= skid_pc_q;
          out_target_q  <= skid_target_q;
          skid_valid_q  <= 1'b0;
        end else if (accept) begin
          out_valid_q   <= 1'b1;
          out_imm_q     <= dec_imm;
          out_fmt_q     <= dec_fmt;
          out_illegal_q <= dec_illegal;
          out_pc_q      <= bus.in_pc;
          out_target_q  <= dec_target;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (accept && SKID) begin
        skid_valid_q   <= 1'b1;
        skid_imm_q     <= dec_imm;
        skid_fmt_q     <= dec_fmt;
        skid_illegal_q <= dec_illegal;
        skid_pc_q      <= bus.in_pc;
        skid_target_q  <= dec_target;
      end
      // Ready next cycle unless the skid entry is (or is becoming) occupied.
      in_ready_q <= out_free ? 1'b1 : ~(skid_valid_q | accept);
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_fmt     = out_fmt_q;
  assign bus.out_illegal = out_illegal_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_target  = out_target_q;

endmodule

// File: tb/tb_id_imm_gen_stage.sv
// Self-checking bench: XLEN=32 and XLEN=64 stages driven in lockstep against a FIFO reference model.
module tb_id_imm_gen_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  id_imm_gen_stage_if #(.XLEN(32)) bus32 ();
  id_imm_gen_stage_if #(.XLEN(64)) bus64 ();

  id_imm_gen_stage #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32));
  id_imm_gen_stage #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus64));

  typedef struct {
    logic [63:0] imm;
    logic [63:0] pc;
    logic [63:0] target;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference: spec's bit-field rules, sign extended by signed arithmetic to 64 bits.
  function automatic exp_t ref_entry(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    logic signed [11:0] t12;
    logic signed [12:0] t13;
    logic signed [20:0] t21;
    logic signed [31:0] t32;
    longint v;
    v = 0;
    e.ill = 1'b0;
    case (i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        t12 = i[31:20]; v = t12; e.fmt = 3'd1;
      end
      7'b0100011: begin
        t12 = {i[31:25], i[11:7]}; v = t12; e.fmt = 3'd2;
      end
      7'b1100011: begin
        t13 = {i[31], i[7], i[30:25], i[11:8], 1'b0}; v = t13; e.fmt = 3'd3;
      end
      7'b0110111, 7'b0010111: begin
        t32 = {i[31:12], 12'b0}; v = t32; e.fmt = 3'd4;
      end
      7'b1101111: begin
        t21 = {i[31], i[19:12], i[20], i[30:21], 1'b0}; v = t21; e.fmt = 3'd5;
      end
      7'b0110011: begin
        v = 0; e.fmt = 3'd0;
      end
      default: begin
        v = 0; e.fmt = 3'd7; e.ill = 1'b1;
      end
    endcase
    e.imm    = v;
    e.pc     = {32'b0, pc};
    e.target = e.imm + e.pc;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    bus32.in_valid  = v;    bus64.in_valid  = v;
    bus32.in_inst   = inst; bus64.in_inst   = inst;
    bus32.in_pc     = pc;   bus64.in_pc     = {32'b0, pc};
    bus32.out_ready = ordy; bus64.out_ready = ordy;
    flush = fl;
  endtask

  task automatic check_out();
    exp_t e;
    chk("out_valid32", 64'(bus32.out_valid), 64'(q.size() > 0));
    chk("out_valid64", 64'(bus64.out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      e = q[0];
      chk("imm32", 64'(bus32.out_imm), 64'(e.imm[31:0]));
      chk("fmt32", 64'(bus32.out_fmt), 64'(e.fmt));
      chk("ill32", 64'(bus32.out_illegal), 64'(e.ill));
      chk("pc32", 64'(bus32.out_pc), 64'(e.pc[31:0]));
      chk("tgt32", 64'(bus32.out_target), 64'(e.target[31:0]));
      chk("imm64", bus64.out_imm, e.imm);
      chk("fmt64", 64'(bus64.out_fmt), 64'(e.fmt));
      chk("pc64", bus64.out_pc, e.pc);
      chk("tgt64", bus64.out_target, e.target);
    end
  endtask

  // One clock: check ready, take the edge, advance the model, check outputs.
  task automatic cyc();
    logic rdy, acc, ordy, fl;
    logic [31:0] inst, pc;
    rdy  = (q.size() < 2);
    chk("in_ready32", 64'(bus32.in_ready), 64'(rdy));
    chk("in_ready64", 64'(bus64.in_ready), 64'(rdy));
    acc  = bus32.in_valid & rdy;
    ordy = bus32.out_ready;
    fl   = flush;
    inst = bus32.in_inst;
    pc   = bus32.in_pc;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (acc) q.push_back(ref_entry(inst, pc));
    end
    #1;
    check_out();
  endtask

  logic [6:0] ops [0:9] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011,
                            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011};

  initial begin
    logic [31:0] r;
    logic [6:0]  opc;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #12;
    chk("rst_valid", 64'(bus32.out_valid), 64'd0);
    chk("rst_ready", 64'(bus32.in_ready), 64'd1);
    chk("rst_imm", 64'(bus32.out_imm), 64'd0);
    chk("rst_pc", 64'(bus32.out_pc), 64'd0);
    chk("rst_tgt", 64'(bus32.out_target), 64'd0);
    chk("rst_fmt", 64'(bus32.out_fmt), 64'd0);
    chk("rst_ill", 64'(bus32.out_illegal), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. streaming, no backpressure
    drive(1'b1, 32'h014AAA93, 32'h0, 1'b1, 1'b0); cyc();
    chk("addi_imm", 64'(bus32.out_imm), 64'd20);
    drive(1'b1, 32'h014AAA83, 32'h0, 1'b1, 1'b0); cyc();
    chk("lw_imm", 64'(bus32.out_imm), 64'd20);
    drive(1'b1, 32'h015AAA23, 32'h0, 1'b1, 1'b0); cyc();
    chk("sw_imm", 64'(bus32.out_imm), 64'd20);
    drive(1'b1, 32'h01555A63, 32'h0, 1'b1, 1'b0); cyc();
    chk("beq_imm", 64'(bus32.out_imm), 64'd20);
    chk("beq_fmt", 64'(bus32.out_fmt), 64'd3);

    // 2. sign and format
    drive(1'b1, 32'hFFF00093, 32'h0, 1'b1, 1'b0); cyc();
    chk("neg_imm", 64'(bus32.out_imm), 64'hFFFFFFFF);
    drive(1'b1, 32'h12345037, 32'h0, 1'b1, 1'b0); cyc();
    chk("lui_imm", 64'(bus32.out_imm), 64'h12345000);
    drive(1'b1, 32'hFFDFF06F, 32'h100, 1'b1, 1'b0); cyc();
    chk("jal_imm32", 64'(bus32.out_imm), 64'hFFFFFFFC);
    chk("jal_tgt32", 64'(bus32.out_target), 64'h000000FC);
    chk("jal_imm64", bus64.out_imm, 64'hFFFFFFFFFFFFFFFC);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); cyc();

    // 3. backpressure: A, B accepted, C refused until release
    drive(1'b1, 32'h00100093, 32'hA0, 1'b0, 1'b0); cyc();
    drive(1'b1, 32'h00200093, 32'hB0, 1'b0, 1'b0); cyc();
    drive(1'b1, 32'h00300093, 32'hC0, 1'b0, 1'b0);
    chk("bp_c_refused", 64'(bus32.in_ready), 64'd0);
    cyc();
    chk("bp_head_a", 64'(bus32.out_pc), 64'hA0);
    drive(1'b1, 32'h00300093, 32'hC0, 1'b1, 1'b0); cyc();
    chk("bp_b_next", 64'(bus32.out_pc), 64'hB0);
    cyc();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cyc();
    chk("bp_c_last", 64'(bus32.out_pc), 64'hC0);
    cyc();

    // 4. flush with output, skid and input all live
    drive(1'b1, 32'h00400093, 32'hD0, 1'b0, 1'b0); cyc();
    drive(1'b1, 32'h00500093, 32'hE0, 1'b0, 1'b0); cyc();
    drive(1'b1, 32'h00600093, 32'hF0, 1'b0, 1'b1); cyc();
    chk("fl_valid", 64'(bus32.out_valid), 64'd0);
    chk("fl_ready", 64'(bus32.in_ready), 64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (3) cyc();

    // 5. illegal opcode keeps streaming
    drive(1'b1, 32'h0000007F, 32'h10, 1'b1, 1'b0); cyc();
    chk("ill_flag", 64'(bus32.out_illegal), 64'd1);
    chk("ill_fmt", 64'(bus32.out_fmt), 64'd7);
    chk("ill_imm", 64'(bus32.out_imm), 64'd0);
    drive(1'b1, 32'h014AAA93, 32'h14, 1'b1, 1'b0); cyc();
    chk("ill_next", 64'(bus32.out_imm), 64'd20);

    // 6. async reset mid-stall
    drive(1'b1, 32'h00700093, 32'h20, 1'b0, 1'b0); cyc();
    cyc();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus32.out_valid), 64'd0);
    chk("arst_valid64", 64'(bus64.out_valid), 64'd0);
    chk("arst_ready", 64'(bus32.in_ready), 64'd1);
    q.delete();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 32'h014AAA93, 32'h0, 1'b1, 1'b0); cyc();
    chk("arst_addi", 64'(bus32.out_imm), 64'd20);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      r = $urandom();
      if ($urandom_range(0, 9) == 0) opc = r[6:0];
      else opc = ops[$urandom_range(0, 9)];
      drive($urandom_range(0, 3) != 0, {r[31:7], opc}, $urandom(),
            $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
